// File: rtl/decoder_pkg.sv
// decoder_pkg: shared definitions for the scanning decoder.
//   MODE_* / DIR_*  : encodings of the mode and dir inputs
//   MAX_N           : widest select the decode helper supports
//   onehot_decode() : bit idx set in a 2^MAX_N vector; callers truncate to 2^n
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    localparam int MAX_N = 8;

    function automatic logic [(1<<MAX_N)-1:0] onehot_decode(input int n,
                                                             input logic [MAX_N-1:0] idx);
        logic [(1<<MAX_N)-1:0] r;
        r = '0;
        // Indices outside the 2^n live lines decode to nothing.
        if (int'(idx) < (1 << n))
            r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running 0..DIV-1 counter that paces the scan.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, counter -> 0
//   en   : count enable; counter holds while low
//   clr  : synchronous clear to 0 (wins over en)
//   tick : terminal-count strobe, asserted while the count is about to wrap
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // One bit minimum so DIV=1 still has a (constant-zero) counter.
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TC = W'(DIV - 1);

    logic [W-1:0] cnt;

    // A cleared cycle never counts as terminal, so a clear also swallows the step.
    assign tick = en & ~clr & (cnt == TC);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder with an optional scan mode.
//   clk, rst : clock, synchronous active-high reset
//   en       : 0 blanks y, holds idx and prescaler, clears wrap
//   mode     : 0 direct decode of w, 1 scan
//   dir      : scan direction, 0 up / 1 down
//   load     : scan mode, load w into idx and restart the prescaler
//   w        : select value
//   y        : one-hot decode of idx, y[0] = line 0, inverted when ACTIVE_LOW
//   idx      : registered index
//   wrap     : one-cycle pulse when the scan index wraps around
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           mode,
    input  logic           dir,
    input  logic           load,
    input  logic [N-1:0]   w,
    output logic [0:(1<<N)-1] y,
    output logic [N-1:0]   idx,
    output logic           wrap
);

    localparam int LINES = 1 << N;

    logic             mode_q;
    logic             mode_chg;
    logic             clr;
    logic             tick;
    logic [N-1:0]     idx_nxt;
    logic             wrap_nxt;
    logic [LINES-1:0] dec;
    logic [0:LINES-1] y_nxt;

    assign mode_chg = (mode != mode_q);

    // Prescaler restarts on a mode change, in direct mode, and on a load.
    assign clr = en & (mode_chg | (mode == MODE_DIRECT) | load);

    scan_prescaler #(.DIV(DIV)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        idx_nxt  = idx;
        wrap_nxt = 1'b0;
        if (mode == MODE_DIRECT || load) begin
            idx_nxt = w;
        end else if (tick) begin
            if (dir == DIR_UP) begin
                idx_nxt  = idx + 1'b1;
                wrap_nxt = &idx;
            end else begin
                idx_nxt  = idx - 1'b1;
                wrap_nxt = ~|idx;
            end
        end
    end

    // y is decoded from the next index so it lands on the same edge as idx.
    assign dec = LINES'(onehot_decode(N, MAX_N'(idx_nxt)));

    always_comb begin
        y_nxt = '0;
        for (int i = 0; i < LINES; i++)
            y_nxt[i] = dec[i] ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            wrap   <= 1'b0;
            y      <= {LINES{ACTIVE_LOW}};
            mode_q <= MODE_DIRECT;
        end else if (!en) begin
            wrap   <= 1'b0;
            y      <= {LINES{ACTIVE_LOW}};
        end else begin
            idx    <= idx_nxt;
            wrap   <= wrap_nxt;
            y      <= y_nxt;
            mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed plan plus randomized traffic against a behavioural
// model; two DUTs share stimulus: (N=3,DIV=4,active-high) and (N=3,DIV=1,active-low).
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst, en, mode, dir, load;
    logic [2:0] w;
    logic [0:7] y_a, y_b;
    logic [2:0] idx_a, idx_b;
    logic       wrap_a, wrap_b;

    int checks = 0;
    int errs   = 0;

    // model state per instance: 0 = DIV4/high, 1 = DIV1/low
    int m_idx[2];
    int m_pre[2];
    bit m_mprev[2];
    bit m_wrap[2];
    bit m_on[2];
    int divs[2] = '{4, 1};
    bit al[2]   = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    decoder_scan #(.N(3), .DIV(4), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .w(w), .y(y_a), .idx(idx_a), .wrap(wrap_a)
    );

    decoder_scan #(.N(3), .DIV(1), .ACTIVE_LOW(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .w(w), .y(y_b), .idx(idx_b), .wrap(wrap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural reference: what one clock edge should do given current inputs.
    task automatic mstep(input int k);
        if (rst) begin
            m_idx[k] = 0; m_pre[k] = 0; m_mprev[k] = 1'b0; m_wrap[k] = 1'b0; m_on[k] = 1'b0;
        end else if (!en) begin
            m_wrap[k] = 1'b0; m_on[k] = 1'b0;
        end else begin
            m_on[k] = 1'b1;
            m_wrap[k] = 1'b0;
            if (!mode) begin
                m_idx[k] = int'(w); m_pre[k] = 0;
            end else if (load) begin
                m_idx[k] = int'(w); m_pre[k] = 0;
            end else if (mode != m_mprev[k]) begin
                m_pre[k] = 0;
            end else if (m_pre[k] == divs[k] - 1) begin
                m_pre[k] = 0;
                if (!dir) begin
                    m_wrap[k] = (m_idx[k] == 7);
                    m_idx[k]  = (m_idx[k] + 1) % 8;
                end else begin
                    m_wrap[k] = (m_idx[k] == 0);
                    m_idx[k]  = (m_idx[k] + 7) % 8;
                end
            end else begin
                m_pre[k]++;
            end
            m_mprev[k] = mode;
        end
    endtask

    function automatic logic [0:7] exp_y(input int k);
        logic [0:7] e;
        e = al[k] ? 8'hFF : 8'h00;
        if (m_on[k])
            e[m_idx[k]] = ~al[k];
        return e;
    endfunction

    // One clock: advance model, then compare every output of both DUTs.
    task automatic cyc();
        @(posedge clk);
        #1;
        mstep(0);
        mstep(1);
        chk("idx_a",  32'(idx_a),  32'(m_idx[0]));
        chk("wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
        chk("y_a",    32'(y_a),    32'(exp_y(0)));
        chk("idx_b",  32'(idx_b),  32'(m_idx[1]));
        chk("wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
        chk("y_b",    32'(y_b),    32'(exp_y(1)));
    endtask

    initial begin
        logic [7:0] e8;
        rst = 1'b1; en = 1'b1; mode = 1'b1; dir = 1'b0; load = 1'b0; w = 3'd0;

        // reset held two clocks, then release
        cyc();
        chk("rst_y", 32'(y_a), 32'h00);
        chk("rst_idx", 32'(idx_a), 32'd0);
        cyc();
        chk("rst_wrap", 32'(wrap_a), 32'd0);
        rst = 1'b0;
        cyc();
        chk("rel_y", 32'(y_a), 32'h80);

        // direct sweep
        mode = 1'b0;
        for (int v = 0; v < 8; v++) begin
            w = 3'(v);
            cyc();
            e8 = 8'h80 >> v;
            chk("dir_y", 32'(y_a), 32'(e8));
        end
        en = 1'b0; w = 3'd5;
        cyc();
        chk("dis_y", 32'(y_a), 32'h00);
        chk("dis_idx", 32'(idx_a), 32'd7);
        en = 1'b1;

        // scan up from 6 with wrap
        mode = 1'b1; dir = 1'b0; load = 1'b1; w = 3'd6;
        cyc();
        load = 1'b0;
        repeat (4) cyc();
        chk("up7_idx", 32'(idx_a), 32'd7);
        chk("up7_wrap", 32'(wrap_a), 32'd0);
        repeat (3) begin
            cyc();
            chk("up_nowrap", 32'(wrap_a), 32'd0);
        end
        cyc();
        chk("up0_idx", 32'(idx_a), 32'd0);
        chk("up0_wrap", 32'(wrap_a), 32'd1);
        cyc();
        chk("wrap_pulse", 32'(wrap_a), 32'd0);

        // scan down through 0, then load on a terminal count
        dir = 1'b1;
        repeat (3) cyc();
        chk("dn7_idx", 32'(idx_a), 32'd7);
        chk("dn7_wrap", 32'(wrap_a), 32'd1);
        repeat (3) cyc();
        load = 1'b1; w = 3'd3;
        cyc();
        chk("ld_idx", 32'(idx_a), 32'd3);
        chk("ld_wrap", 32'(wrap_a), 32'd0);
        load = 1'b0;
        repeat (3) cyc();
        chk("ld_hold", 32'(idx_a), 32'd3);
        cyc();
        chk("ld_step", 32'(idx_a), 32'd2);

        // enable freeze mid-prescale
        repeat (2) cyc();
        en = 1'b0;
        repeat (5) begin
            cyc();
            chk("frz_y", 32'(y_a), 32'h00);
            chk("frz_idx", 32'(idx_a), 32'd2);
        end
        en = 1'b1;
        cyc();
        chk("resume_idx", 32'(idx_a), 32'd2);
        chk("resume_y", 32'(y_a), 32'h20);
        cyc();
        chk("resume_step", 32'(idx_a), 32'd1);

        // DIV=1 steps each clock; active-low polarity
        load = 1'b1; w = 3'd5;
        cyc();
        chk("al_y5", 32'(y_b), 32'hFB);
        load = 1'b0;
        cyc();
        chk("div1_step", 32'(idx_b), 32'd4);
        load = 1'b1; w = 3'd2;
        cyc();
        chk("al_y2", 32'(y_b), 32'hDF);
        load = 1'b0; en = 1'b0;
        cyc();
        chk("al_dis", 32'(y_b), 32'hFF);
        en = 1'b1;

        // reset mid-scan, then direct -> scan switch timing
        dir = 1'b0; load = 1'b1; w = 3'd5;
        cyc();
        load = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        chk("mrst_idx", 32'(idx_a), 32'd0);
        chk("mrst_y", 32'(y_a), 32'h00);
        rst = 1'b0; mode = 1'b0; w = 3'd4;
        cyc();
        mode = 1'b1;
        cyc();
        repeat (3) begin
            cyc();
            chk("sw_hold", 32'(idx_a), 32'd4);
        end
        cyc();
        chk("sw_step", 32'(idx_a), 32'd5);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            en   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            dir  = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 9) == 0);
            w    = 3'($urandom_range(0, 7));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
